// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Data wins by default; a bounded data streak forces a fetch grant so fetch cannot starve.
module mem_port_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        if_req_valid_i,
  input  logic [31:0] if_addr_i,
  output logic        if_req_ready_o,
  output logic        if_resp_valid_o,
  output logic [31:0] if_resp_data_o,
  input  logic        dm_req_valid_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  input  logic [3:0]  dm_wstrb_i,
  output logic        dm_req_ready_o,
  output logic        dm_resp_valid_o,
  output logic [31:0] dm_resp_data_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_resp_valid_i,
  input  logic [31:0] mem_resp_data_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  localparam logic [3:0] MaxStreak = 4'(MAX_DATA_STREAK);

  state_e      state_q;
  logic [3:0]  streak_q, streak_d;
  logic        ownerIf_q;
  logic        discard_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] respData_q;
  logic        ifRespValid_q;
  logic        dmRespValid_q;

  logic isIdle, forceIf, dmGrant, ifGrant;

  always_comb begin
    isIdle  = (state_q == IDLE);
    forceIf = if_req_valid_i & ~flush_i & (streak_q == MaxStreak);
    dmGrant = isIdle & dm_req_valid_i & ~forceIf;
    ifGrant = isIdle & if_req_valid_i & ~flush_i & (~dm_req_valid_i | forceIf);
    // A data grant only extends the streak while fetch is actually waiting.
    streak_d = 4'd0;
    if (dmGrant && if_req_valid_i) begin
      streak_d = (streak_q == MaxStreak) ? MaxStreak : streak_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      streak_q      <= 4'd0;
      ownerIf_q     <= 1'b0;
      discard_q     <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      wstrb_q       <= 4'd0;
      respData_q    <= 32'd0;
      ifRespValid_q <= 1'b0;
      dmRespValid_q <= 1'b0;
    end else begin
      ifRespValid_q <= 1'b0;
      dmRespValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dmGrant) begin
            state_q   <= REQ;
            ownerIf_q <= 1'b0;
            we_q      <= dm_we_i;
            addr_q    <= dm_addr_i;
            wdata_q   <= dm_wdata_i;
            wstrb_q   <= dm_we_i ? dm_wstrb_i : 4'd0;
            streak_q  <= streak_d;
          end else if (ifGrant) begin
            state_q   <= REQ;
            ownerIf_q <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= if_addr_i;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            streak_q  <= 4'd0;
          end
        end
        REQ: begin
          if (ownerIf_q && flush_i) discard_q <= 1'b1;
          if (mem_req_ready_i) state_q <= WAIT;
        end
        WAIT: begin
          if (mem_resp_valid_i) begin
            // A flush in the very cycle the response lands still kills the fetch.
            respData_q    <= mem_resp_data_i;
            ifRespValid_q <= ownerIf_q & ~discard_q & ~flush_i;
            dmRespValid_q <= ~ownerIf_q;
            discard_q     <= 1'b0;
            state_q       <= IDLE;
          end else if (ownerIf_q && flush_i) begin
            discard_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_req_ready_o  = ifGrant;
  assign dm_req_ready_o  = dmGrant;
  assign if_resp_valid_o = ifRespValid_q;
  assign if_resp_data_o  = respData_q;
  assign dm_resp_valid_o = dmRespValid_q;
  assign dm_resp_data_o  = respData_q;
  assign mem_req_valid_o = (state_q == REQ);
  assign mem_we_o        = we_q;
  assign mem_addr_o      = addr_q;
  assign mem_wdata_o     = wdata_q;
  assign mem_wstrb_o     = wstrb_q;
  assign busy_o          = ~isIdle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural memory whose
// request stall and response delay are set per scenario.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush;
  logic        if_req_valid;
  logic [31:0] if_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_data;
  logic        dm_req_valid;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_req_ready;
  logic        dm_resp_valid;
  logic [31:0] dm_resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        busy;

  mem_port_arbiter #(.MAX_DATA_STREAK(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .if_req_valid_i(if_req_valid), .if_addr_i(if_addr), .if_req_ready_o(if_req_ready),
    .if_resp_valid_o(if_resp_valid), .if_resp_data_o(if_resp_data),
    .dm_req_valid_i(dm_req_valid), .dm_we_i(dm_we), .dm_addr_i(dm_addr),
    .dm_wdata_i(dm_wdata), .dm_wstrb_i(dm_wstrb), .dm_req_ready_o(dm_req_ready),
    .dm_resp_valid_o(dm_resp_valid), .dm_resp_data_o(dm_resp_data),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_wstrb_o(mem_wstrb), .mem_resp_valid_i(mem_resp_valid),
    .mem_resp_data_i(mem_resp_data), .busy_o(busy)
  );

  // Behavioural memory: stalls acceptance reqStall cycles, answers respDelay cycles into WAIT.
  logic [31:0] memArr [0:1023];
  int          reqStall;
  int          respDelay;
  int          stallCnt;
  int          waitCnt;
  logic        pending;
  logic [31:0] rdData;

  assign mem_req_ready  = mem_req_valid && (stallCnt >= reqStall);
  assign mem_resp_valid = pending && (waitCnt >= respDelay);
  assign mem_resp_data  = rdData;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= 1'b0;
      stallCnt   <= 0;
      waitCnt    <= 0;
      rdData     <= 32'd0;
      memArr[0]  <= 32'd0;
      memArr[64] <= 32'h0000_0013;
    end else begin
      if (mem_req_valid && mem_req_ready) begin
        stallCnt <= 0;
        pending  <= 1'b1;
        waitCnt  <= 0;
        rdData   <= memArr[mem_addr[11:2]];
        if (mem_we) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_wstrb[b]) memArr[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
          end
        end
      end else if (mem_req_valid) begin
        stallCnt <= stallCnt + 1;
      end
      if (pending) begin
        if (mem_resp_valid) pending <= 1'b0;
        else waitCnt <= waitCnt + 1;
      end
    end
  end

  int total = 0;
  int bad   = 0;
  logic sawIfPulse;
  logic [1:0] expGrant [7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic ifv, input logic [31:0] ia, input logic dmv,
                               input logic we, input logic [31:0] da, input logic [31:0] wd,
                               input logic [3:0] ws, input logic fl);
    if_req_valid = ifv;
    if_addr      = ia;
    dm_req_valid = dmv;
    dm_we        = we;
    dm_addr      = da;
    dm_wdata     = wd;
    dm_wstrb     = ws;
    flush        = fl;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleStim();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    reqStall = 0;
    respDelay = 0;
    idleStim();
    #12;
    checkOutput("resetCtrl", 32'({busy, mem_req_valid, if_resp_valid, dm_resp_valid, mem_we, mem_wstrb}), 0);
    checkOutput("resetAddr", mem_addr, 0);
    checkOutput("resetData", if_resp_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single fetch, zero-wait memory
    nextCycle(); applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0); #2;
    checkOutput("fetchReady", 32'({if_req_ready, dm_req_ready}), 32'b10);
    nextCycle(); idleStim(); #2;
    checkOutput("fetchReqValid", 32'(mem_req_valid), 1);
    checkOutput("fetchAddr", mem_addr, 32'h100);
    checkOutput("fetchWeStrb", 32'({mem_we, mem_wstrb}), 0);
    nextCycle(); #2;
    checkOutput("fetchWaitBusy", 32'({busy, mem_req_valid}), 32'b10);
    nextCycle(); #2;
    checkOutput("fetchResp", 32'({if_resp_valid, dm_resp_valid, busy}), 32'b100);
    checkOutput("fetchData", if_resp_data, 32'h0000_0013);

    // Store then load
    nextCycle(); applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF, 1'b0); #2;
    checkOutput("pulseGone", 32'(if_resp_valid), 0);
    checkOutput("storeReady", 32'(dm_req_ready), 1);
    nextCycle(); idleStim(); #2;
    checkOutput("storeWeStrb", 32'({mem_we, mem_wstrb}), 32'h1F);
    checkOutput("storeWdata", mem_wdata, 32'hDEAD_BEEF);
    checkOutput("storeAddr", mem_addr, 32'h2000);
    nextCycle(); #2;
    nextCycle(); applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h2000, 32'd0, 4'hF, 1'b0); #2;
    checkOutput("storeAck", 32'({dm_resp_valid, if_resp_valid}), 32'b10);
    checkOutput("loadReady", 32'(dm_req_ready), 1);
    nextCycle(); idleStim(); #2;
    checkOutput("loadWeStrb", 32'({mem_we, mem_wstrb}), 0);
    nextCycle(); #2;
    nextCycle(); #2;
    checkOutput("loadResp", 32'(dm_resp_valid), 1);
    checkOutput("loadData", dm_resp_data, 32'hDEAD_BEEF);

    // Contention: fetch forced after four back-to-back data grants
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h2000, 32'd0, 4'd0, 1'b0);
    for (int g = 0; g < 7; g++) begin
      #2;
      checkOutput($sformatf("grant%0d", g), 32'({if_req_ready, dm_req_ready}), 32'(expGrant[g]));
      nextCycle(); #2;
      checkOutput($sformatf("noGrantBusy%0d", g), 32'({if_req_ready, dm_req_ready}), 0);
      nextCycle();
      nextCycle();
    end
    idleStim();

    // Flush in IDLE blocks fetch but not data; flush on a data transaction is ignored
    nextCycle(); applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1); #2;
    checkOutput("flushBlocksIf", 32'({if_req_ready, dm_req_ready}), 0);
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h2000, 32'd0, 4'd0, 1'b1); #2;
    checkOutput("flushDmWins", 32'({if_req_ready, dm_req_ready}), 32'b01);
    nextCycle(); applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    nextCycle(); #2;
    nextCycle(); idleStim(); #2;
    checkOutput("flushDmResp", 32'(dm_resp_valid), 1);
    checkOutput("flushDmData", dm_resp_data, 32'hDEAD_BEEF);

    // Flush in the same cycle the fetch response is sampled
    nextCycle(); applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0); #2;
    checkOutput("fetch2Ready", 32'(if_req_ready), 1);
    nextCycle(); idleStim();
    nextCycle(); applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1); #2;
    checkOutput("respCycle", 32'(mem_resp_valid), 1);
    nextCycle(); idleStim(); #2;
    checkOutput("lateFlushDrop", 32'({if_resp_valid, busy}), 0);

    // Flush while the response is stalled, then a data load
    sawIfPulse = 1'b0;
    respDelay = 3;
    nextCycle(); applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0); #2;
    checkOutput("fetch3Ready", 32'(if_req_ready), 1);
    nextCycle(); idleStim();
    nextCycle(); applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1); #2;
    checkOutput("stallBusy", 32'(busy), 1);
    for (int c = 3; c <= 5; c++) begin
      nextCycle(); idleStim(); #2;
      if (if_resp_valid) sawIfPulse = 1'b1;
    end
    checkOutput("busyAtResp", 32'(busy), 1);
    nextCycle(); respDelay = 0;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h2000, 32'd0, 4'd0, 1'b0); #2;
    if (if_resp_valid) sawIfPulse = 1'b1;
    checkOutput("busyFalls", 32'(busy), 0);
    checkOutput("postFlushDmReady", 32'(dm_req_ready), 1);
    nextCycle(); idleStim(); #2;
    if (if_resp_valid) sawIfPulse = 1'b1;
    nextCycle(); #2;
    nextCycle(); #2;
    checkOutput("noIfPulse", 32'(sawIfPulse), 0);
    checkOutput("postFlushDmResp", 32'(dm_resp_valid), 1);
    checkOutput("postFlushDmData", dm_resp_data, 32'hDEAD_BEEF);

    // Memory request stall, then reset while in WAIT
    reqStall = 2;
    respDelay = 3;
    nextCycle(); applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0); #2;
    checkOutput("fetch4Ready", 32'(if_req_ready), 1);
    nextCycle(); idleStim(); #2;
    nextCycle(); #2;
    checkOutput("stallReqValid", 32'(mem_req_valid), 1);
    checkOutput("stallAddr", mem_addr, 32'h100);
    nextCycle(); #2;
    nextCycle(); #2;
    checkOutput("stallWait", 32'({busy, mem_req_valid}), 32'b10);
    nextCycle();
    rst_n = 1'b0;
    #1;
    checkOutput("midResetCtrl", 32'({busy, mem_req_valid, if_resp_valid, dm_resp_valid, mem_we, mem_wstrb}), 0);
    checkOutput("midResetAddr", mem_addr, 0);
    reqStall = 0;
    respDelay = 0;
    nextCycle();
    @(negedge clk);
    rst_n = 1'b1;
    sawIfPulse = 1'b0;
    for (int c = 0; c < 3; c++) begin
      nextCycle(); #2;
      if (if_resp_valid || dm_resp_valid || busy) sawIfPulse = 1'b1;
    end
    checkOutput("noStaleResp", 32'(sawIfPulse), 0);
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0); #2;
    checkOutput("postResetReady", 32'(if_req_ready), 1);
    nextCycle(); idleStim();
    nextCycle();
    nextCycle(); #2;
    checkOutput("postResetResp", 32'(if_resp_valid), 1);
    checkOutput("postResetData", if_resp_data, 32'h0000_0013);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
